// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and history entry layout for the PS/2 key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned HIST_W = 9;
  localparam int unsigned ST_W   = 5;

  // One-hot scan-code decoder states
  typedef enum logic [ST_W-1:0] {
    IDLE    = 5'b00001,
    READY   = 5'b00010,
    EXT     = 5'b00100,
    BRK     = 5'b01000,
    EXT_BRK = 5'b10000
  } state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } hist_entry_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Show-ahead history FIFO of pressed keys; a push into a full FIFO without a pop is dropped.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [HIST_W-1:0] din,
  input  logic              pop,
  output logic [HIST_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              ovf
);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [HIST_W-1:0]  mem [DEPTH];
  logic               pop_ok_c;
  logic               push_ok_c;

  // Extra pointer bit separates full from empty when the indices coincide
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign pop_ok_c  = pop & ~empty;
  assign push_ok_c = push & (~full | pop_ok_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ovf <= push & ~push_ok_c;
      if (push_ok_c) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok_c) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker: decodes make/break/E0 sequences, counts presses, keeps a key history.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses counting/logging of typematic repeats.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned HIST_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ps2_data,
  input  logic              ps2_valid,
  output logic [7:0]        key_code,
  output logic              key_ext,
  output logic              key_held,
  output logic              seg_enable,
  output logic [CNT_W-1:0]  press_cnt,
  output logic              proto_err,
  output logic [HIST_W-1:0] hist_dout,
  output logic              hist_empty,
  output logic              hist_full,
  input  logic              hist_rd,
  output logic              hist_ovf
);

  localparam int unsigned HIST_AW = $clog2(HIST_DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic        make_c;
  logic        make_ext_c;
  logic        rel_c;
  logic        err_c;
  logic        count_c;
  hist_entry_t push_entry_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Sequence decoder: classifies each byte as make, release, prefix or error
  always_comb begin
    state_nxt  = state;
    make_c     = 1'b0;
    make_ext_c = 1'b0;
    rel_c      = 1'b0;
    err_c      = 1'b0;
    case (state)
      IDLE: state_nxt = READY;
      READY: begin
        if (ps2_valid) begin
          if (ps2_data == PS2_EXT)      state_nxt = EXT;
          else if (ps2_data == PS2_BRK) state_nxt = BRK;
          else                          make_c    = 1'b1;
        end
      end
      EXT: begin
        if (ps2_valid) begin
          if (ps2_data == PS2_BRK) begin
            state_nxt = EXT_BRK;
          end else if (ps2_data == PS2_EXT) begin
            err_c = 1'b1;
          end else begin
            make_c     = 1'b1;
            make_ext_c = 1'b1;
            state_nxt  = READY;
          end
        end
      end
      BRK, EXT_BRK: begin
        if (ps2_valid) begin
          state_nxt = READY;
          if (is_prefix(ps2_data)) begin
            err_c = 1'b1;
          end else if ((ps2_data == key_code) && (key_ext == (state == EXT_BRK))) begin
            rel_c = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // A held key re-sent by the keyboard's auto-repeat is not a new press
  assign count_c = make_c & ~(key_held && (ps2_data == key_code) && (make_ext_c == key_ext));
`else
  assign count_c = make_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_held  <= 1'b0;
      press_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= err_c;
      if (make_c) begin
        key_code <= ps2_data;
        key_ext  <= make_ext_c;
        key_held <= 1'b1;
      end else if (rel_c) begin
        key_held <= 1'b0;
      end
      if (count_c) begin
        press_cnt <= press_cnt + CNT_W'(1);
      end
    end
  end

  assign seg_enable = key_held;

  assign push_entry_c.ext  = make_ext_c;
  assign push_entry_c.code = ps2_data;

  ps2_key_fifo #(
    .DEPTH (HIST_DEPTH),
    .AW    (HIST_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (count_c),
    .din   (push_entry_c),
    .pop   (hist_rd),
    .dout  (hist_dout),
    .empty (hist_empty),
    .full  (hist_full),
    .ovf   (hist_ovf)
  );

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Parametrised PS/2 scan-code tracker between the PS/2 receiver (byte + valid strobe) and the seven-segment display driver.
- Decodes make, break (F0) and extended (E0) sequences and tracks the currently held key.
- Counts key presses and buffers a history of pressed keys in a small show-ahead FIFO that a consumer pops.

Parameters:
- CNT_W, 8: width of the press counter.
- HIST_DEPTH, 8: history FIFO entries; power of 2, ≥2.
- HIST_AW, $clog2(HIST_DEPTH): FIFO address width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- ps2_data  in  8  received scan-code byte.
- ps2_valid  in  1  one-cycle strobe; ps2_data valid this cycle.
- key_code  out  8  last make code.
- key_ext  out  1  last make code was E0-prefixed.
- key_held  out  1  last make key not yet released.
- seg_enable  out  1  display enable; equals key_held.
- press_cnt  out  CNT_W  accepted make events, wrapping.
- proto_err  out  1  one-cycle pulse on a malformed sequence.
- hist_dout  out  9  FIFO head {ext, code}; valid when !hist_empty.
- hist_empty  out  1  FIFO empty.
- hist_full  out  1  FIFO full.
- hist_rd  in  1  pop head; ignored when empty.
- hist_ovf  out  1  one-cycle pulse when a push is dropped.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - key_code=0, key_ext=0, key_held=0, press_cnt=0.
  - proto_err=0, hist_ovf=0.
  - FIFO pointers=0, so hist_empty=1, hist_full=0, hist_dout=0.
- FSM is one-hot: IDLE, READY, EXT, BRK, EXT_BRK. IDLE→READY unconditionally on the first clock after reset. Other transitions happen only when ps2_valid=1; otherwise the state holds.
- READY:
  - data=E0 → EXT.
  - data=F0 → BRK.
  - Any other byte is a make event with ext=0; stay READY.
- EXT:
  - data=F0 → EXT_BRK.
  - data=E0 → proto_err pulse, stay EXT.
  - Any other byte is a make event with ext=1; → READY.
- BRK:
  - If data==key_code and key_ext==0, clear key_held.
  - data=E0 or F0 → proto_err pulse, no release.
  - Always → READY.
- EXT_BRK: same as BRK with the match condition key_ext==1; → READY.
- Make event, registered on the same edge as the valid byte; outputs visible next cycle:
  - key_code<=data, key_ext<=ext, key_held<=1.
  - press_cnt<=press_cnt+1, wrapping from 2^CNT_W-1 to 0.
  - Push {ext, data} into the FIFO.
- A release whose code does not match the held key is ignored silently; key_held stays unchanged.
- FIFO:
  - Show-ahead: hist_dout is driven from the read pointer.
  - Push when full → entry dropped, hist_ovf pulses, pointers unchanged.
  - Push and pop in the same cycle when full → both proceed, stays full.
  - Push and pop in the same cycle when empty → push only.
  - Occupancy is tracked with an extra pointer bit (HIST_AW+1 bits).
- Reset asserted mid-sequence (e.g. after E0) → return to IDLE and clear all state, including the FIFO.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined: a make event with {ext,data}=={key_ext,key_code} while key_held=1 is a typematic repeat. It does not increment press_cnt and does not push; key_held stays 1.
- Undefined: every make byte, including repeats, increments press_cnt and pushes.

Decomposition:
- Shared package ps2_pkg:
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - One-hot state encodings.
  - Entry width constant HIST_W=9.
- Sub-module ps2_key_fifo (parameter DEPTH; width HIST_W): push, pop, dout, empty, full, ovf. Instantiated once.

Test Plan:
- Reset released, then 1C → key_code=1C, key_ext=0, key_held=1, seg_enable=1, press_cnt=1, hist_dout=0x01C, hist_empty=0.
- 1C, F0, 1C → key_held=0 after the last byte; press_cnt=1; FSM back in READY.
- E0, 75, E0, F0, 75 → key_ext=1, key_code=75 and held after the second byte; released after the fifth byte; hist_dout=0x175.
- 9 distinct makes with no pops (HIST_DEPTH=8) → hist_full=1; the 9th push pulses hist_ovf; popping 8 times returns the first 8 codes in order, then hist_empty=1.
- 1C, 1C, 1C (key held): filter undefined → press_cnt=3 and 3 entries; filter defined → press_cnt=1 and 1 entry.
- F0, F0 → proto_err pulses once and no release; with CNT_W=2, 5 makes → press_cnt=1 (wrap).
